// File: rtl/bytecode_fetch.sv
// bytecode_fetch: instruction fetch unit for the bytecode decoder.
// Reads program memory one byte at a time, presents the opcode to the
// decoder, collects the 0-2 argument bytes that the decoder's argc asks for,
// and hands the assembled instruction over a valid/ready handshake. Taken
// branches redirect the program counter relative to insn_pc.
//
// Parameters:
//   ADDR_WIDTH  program memory address width; the pc wraps modulo 2^ADDR_WIDTH
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   mem_addr, mem_rd             byte read request (one cycle per byte)
//   mem_data, mem_valid          read response
//   opcode, argc                 opcode to decoder, argument count back
//   arg, insn_pc, insn_valid     assembled instruction (big-endian arg)
//   insn_ready                   control unit accepts the instruction
//   branch, branch_off           taken branch and signed offset at acceptance
// Build option:
//   BYTECODE_PREFETCH_EN  while an instruction waits in ISSUE, fetch the next
//                         sequential opcode into a one-byte buffer.
module bytecode_fetch #(
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  input  logic [7:0]            mem_data,
  input  logic                  mem_valid,
  output logic [7:0]            opcode,
  input  logic [1:0]            argc,
  output logic [15:0]           arg,
  output logic [ADDR_WIDTH-1:0] insn_pc,
  output logic                  insn_valid,
  input  logic                  insn_ready,
  input  logic                  branch,
  input  logic [15:0]           branch_off
);

  typedef enum logic [2:0] {
    S_FETCH, S_WAIT_OP, S_DECODE, S_FETCH_ARG, S_WAIT_ARG, S_ISSUE
  } state_t;

  state_t                r_state, w_next;
  logic                  r_live;     // low for the first cycle after reset release
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] r_insn_pc;
  logic [7:0]            r_opcode;
  logic [15:0]           r_arg;
  logic [1:0]            r_nargs;    // effective argument count (3 folded to 2)
  logic                  r_idx;      // index of the argument byte being fetched

  logic [1:0]            w_nargs;
  logic                  w_accept;
  logic                  w_last_arg;
  logic                  w_fetch_go;
  logic [ADDR_WIDTH-1:0] w_seq_pc;
  logic [ADDR_WIDTH-1:0] w_br_pc;
  logic [ADDR_WIDTH-1:0] w_off_ext;
  logic [ADDR_WIDTH-1:0] w_arg_addr;

  assign w_nargs    = (argc == 2'd3) ? 2'd2 : argc;
  assign w_accept   = (r_state == S_ISSUE) && insn_ready;
  assign w_last_arg = (({1'b0, r_idx} + 2'd1) == r_nargs);
  assign w_seq_pc   = r_insn_pc + ADDR_WIDTH'(r_nargs + 2'd1);
  assign w_off_ext  = ADDR_WIDTH'($signed(branch_off));
  assign w_br_pc    = r_insn_pc + w_off_ext;
  assign w_arg_addr = r_insn_pc + ADDR_WIDTH'({1'b0, r_idx} + 2'd1);

`ifdef BYTECODE_PREFETCH_EN
  logic       r_pf_out;   // prefetch read outstanding
  logic       r_pf_full;  // buffer holds the next sequential opcode
  logic       r_pf_drop;  // a prefetch response must be discarded
  logic [7:0] r_pf_data;
  logic       w_pf_issue;
  logic       w_pf_hit;
  logic [7:0] w_pf_byte;

  assign w_pf_issue = (r_state == S_ISSUE) && !r_pf_out && !r_pf_full;
  // A response landing in the acceptance cycle is used as if already buffered.
  assign w_pf_hit   = r_pf_full || (r_pf_out && mem_valid);
  assign w_pf_byte  = r_pf_full ? r_pf_data : mem_data;
  // After a branch the stale prefetch must retire before the new fetch.
  assign w_fetch_go = r_live && !r_pf_drop;
`else
  assign w_fetch_go = r_live;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_FETCH:     if (w_fetch_go) w_next = S_WAIT_OP;
      S_WAIT_OP:   if (mem_valid) w_next = S_DECODE;
      S_DECODE:    w_next = (w_nargs == 2'd0) ? S_ISSUE : S_FETCH_ARG;
      S_FETCH_ARG: w_next = S_WAIT_ARG;
      S_WAIT_ARG:  if (mem_valid) w_next = w_last_arg ? S_ISSUE : S_FETCH_ARG;
      S_ISSUE: begin
        if (w_accept) begin
`ifdef BYTECODE_PREFETCH_EN
          if (branch)                        w_next = S_FETCH;
          else if (w_pf_hit)                 w_next = S_DECODE;
          else if (r_pf_out || w_pf_issue)   w_next = S_WAIT_OP;
          else                               w_next = S_FETCH;
`else
          w_next = S_FETCH;
`endif
        end
      end
      default:     w_next = S_FETCH;
    endcase
  end

  // Output logic
  always_comb begin
    mem_rd   = 1'b0;
    mem_addr = r_pc;
    unique case (r_state)
      S_FETCH:     mem_rd = w_fetch_go;
      S_FETCH_ARG: begin
        mem_rd   = 1'b1;
        mem_addr = w_arg_addr;
      end
`ifdef BYTECODE_PREFETCH_EN
      S_ISSUE: begin
        if (w_pf_issue) begin
          mem_rd   = 1'b1;
          mem_addr = w_seq_pc;
        end
      end
`endif
      default: ;
    endcase
  end

  assign insn_valid = (r_state == S_ISSUE);
  assign opcode     = r_opcode;
  assign arg        = r_arg;
  assign insn_pc    = r_insn_pc;

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live    <= 1'b0;
      r_pc      <= '0;
      r_insn_pc <= '0;
      r_opcode  <= '0;
      r_arg     <= '0;
      r_nargs   <= '0;
      r_idx     <= 1'b0;
    end else begin
      r_live <= 1'b1;
      unique case (r_state)
        S_WAIT_OP: begin
          if (mem_valid) begin
            r_opcode  <= mem_data;
            r_insn_pc <= r_pc;
            r_arg     <= '0;
          end
        end
        S_DECODE: begin
          r_nargs <= w_nargs;
          r_idx   <= 1'b0;
        end
        S_WAIT_ARG: begin
          // Shifting left gives {00,b1} for one byte and {b1,b2} for two.
          if (mem_valid) begin
            r_arg <= {r_arg[7:0], mem_data};
            r_idx <= r_idx + 1'b1;
          end
        end
        S_ISSUE: begin
          if (w_accept) begin
            r_pc <= branch ? w_br_pc : w_seq_pc;
`ifdef BYTECODE_PREFETCH_EN
            if (!branch && w_pf_hit) begin
              r_opcode  <= w_pf_byte;
              r_insn_pc <= w_seq_pc;
              r_arg     <= '0;
            end
`endif
          end
        end
        default: ;
      endcase
    end
  end

`ifdef BYTECODE_PREFETCH_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pf_out  <= 1'b0;
      r_pf_full <= 1'b0;
      r_pf_drop <= 1'b0;
      r_pf_data <= '0;
    end else if (w_accept && branch) begin
      // An in-flight prefetch (including one issued this cycle) becomes stale.
      r_pf_out  <= 1'b0;
      r_pf_full <= 1'b0;
      r_pf_drop <= (r_pf_out && !mem_valid) || w_pf_issue;
    end else begin
      if (r_pf_drop && mem_valid) r_pf_drop <= 1'b0;
      if (w_pf_issue)                  r_pf_out <= 1'b1;
      else if (r_pf_out && mem_valid)  r_pf_out <= 1'b0;
      if (w_accept) begin
        r_pf_full <= 1'b0;
      end else if ((r_state == S_ISSUE) && r_pf_out && mem_valid) begin
        r_pf_full <= 1'b1;
        r_pf_data <= mem_data;
      end
    end
  end
`endif

endmodule

// File: doc/bytecode_fetch.md
# bytecode_fetch

Instruction fetch unit in front of the bytecode decoder. Reads the byte-wide program memory and presents one opcode at a time to the decoder. Uses the decoder's argument count to collect 0–2 in-line argument bytes. Hands the assembled instruction to the control unit over a valid/ready handshake and redirects the program counter on taken branches.

## Interface
Parameters:
- `ADDR_WIDTH`, default 16: program memory address width; the program counter wraps modulo 2^ADDR_WIDTH.

Ports:
- `clk`, input, 1: single clock; all state is updated on the rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `mem_addr`, output, ADDR_WIDTH: program memory byte address.
- `mem_rd`, output, 1: one-cycle read request. At most one read is outstanding at any time.
- `mem_data`, input, 8: read data, valid when `mem_valid` is high.
- `mem_valid`, input, 1: read response, arriving at least 1 cycle after `mem_rd`.
- `opcode`, output, 8: current opcode. It feeds the decoder's opcode input.
- `argc`, input, 2: decoder argument count for `opcode`, combinational from `opcode`.
- `arg`, output, 16: argument bytes in big-endian order, zero-extended.
- `insn_pc`, output, ADDR_WIDTH: address of the current opcode byte.
- `insn_valid`, output, 1: `opcode`, `arg` and `insn_pc` are complete.
- `insn_ready`, input, 1: the control unit accepts the instruction.
- `branch`, input, 1: the accepted instruction is a taken branch.
- `branch_off`, input, 16: signed branch offset, relative to `insn_pc`.

## Operation
- States:
  - FETCH: assert `mem_rd`, with `mem_addr` = pc.
  - WAIT_OP: on `mem_valid`, load `opcode` from `mem_data`.
  - DECODE: sample `argc`, then go to ISSUE if `argc` = 0, otherwise to FETCH_ARG.
  - FETCH_ARG: assert `mem_rd`, with `mem_addr` = `insn_pc` + 1 + index.
  - WAIT_ARG: capture the argument byte. Loop back to FETCH_ARG until `argc` bytes have been collected, then go to ISSUE.
  - ISSUE: hold `insn_valid`.
- Argument assembly:
  - `argc` = 1: `arg` = {8'h00, b1}.
  - `argc` = 2: `arg` = {b1, b2}.
  - `argc` = 3 is treated as 2.
  - `arg` is cleared to 0 on entry to DECODE.
- Handshake: an instruction is accepted when `insn_valid` and `insn_ready` are both high.
  - `opcode`, `arg` and `insn_pc` stay stable while `insn_valid` is high and the instruction has not been accepted.
  - `insn_valid` never drops without an acceptance.
- Next pc, computed at acceptance:
  - `branch` = 1: next pc = `insn_pc` + sign-extended `branch_off`, truncated to ADDR_WIDTH, so the address wraps.
  - `branch` = 0: next pc = `insn_pc` + 1 + `argc`, also wrapping.
  - `branch` and `branch_off` are ignored when no acceptance happens.
- `mem_valid` is ignored outside the wait states (and outside an outstanding prefetch, when prefetch is compiled in).
- Reset values:
  - Outputs: `opcode` = 8'h00 (NOP), `arg` = 0, `insn_pc` = 0, `insn_valid` = 0, `mem_rd` = 0, `mem_addr` = 0.
  - Internal: pc = 0, state = FETCH.
  - Reset asserted mid-fetch abandons the read. Any response that arrives after reset is released is dropped unless the state machine is in a wait state.

## Timing
- With memory that responds in the next cycle (`mem_rd` at t, `mem_valid` at t+1):
  - `argc` = 0: `insn_valid` at t+3.
  - `argc` = 1: `insn_valid` at t+5.
  - `argc` = 2: `insn_valid` at t+7.
- Acceptance at cycle a: FETCH for the next pc at a+1.
- Each extra memory wait cycle adds exactly one cycle of latency.
- `mem_rd` is high for exactly one cycle per byte fetched.

## Configuration
- `BYTECODE_PREFETCH_EN` defined:
  - While in ISSUE with no read outstanding, fetch the byte at `insn_pc` + 1 + `argc` into a one-byte buffer.
  - Acceptance without branch:
    - Buffer full: go straight to DECODE with the buffered opcode, so the next `insn_valid` comes 2 cycles earlier.
    - Read still outstanding: go to WAIT_OP.
  - Acceptance with branch:
    - Invalidate the buffer.
    - If the read is still outstanding, drop its response, then FETCH from the branch target.
- `BYTECODE_PREFETCH_EN` undefined: no buffer, and no reads are issued during ISSUE.

## Test plan
- Reset with `rst_n` low, then release: all outputs are at their reset values. The first `mem_rd` comes one cycle after release, with `mem_addr` = 0.
- Memory 0x00: 0x04, 0x05, with `argc` = 0 for both, and `insn_ready` tied high:
  - Issues `opcode` 0x04 with `insn_pc` 0.
  - Then `opcode` 0x05 with `insn_pc` 1.
  - Each instruction takes 4 cycles without prefetch.
- Memory 0x10: 0xA7 0xFF 0xF0, with `argc` = 2:
  - `arg` = 0xFFF0.
  - Accept with `branch` = 1 and `branch_off` = 0xFFF0: next fetch address is 0x0000.
- `argc` = 1 with byte 0x85: `arg` = 0x0085. Holding `insn_ready` low for 5 cycles keeps all outputs stable, and no `mem_rd` is issued without prefetch.
- `insn_pc` = 0xFFFE with `argc` = 2, accepted without branch: next `mem_addr` = 0x0001 (wrap).
- Prefetch compiled in, with a 3-cycle memory:
  - A branch accepted while the prefetch is outstanding: the stale response is discarded and the next `opcode` comes from the branch target.
  - Acceptance without branch after the buffer has filled: `insn_valid` returns 2 cycles after acceptance.
